// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-port memory between instruction fetch
// and load/store; alternates on contention, one-cycle ack, sticky timeout error.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state_q;
  logic              last_d_q;
  logic [7:0]        cnt_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              if_ack_q, d_ack_q, err_q;
  logic              i_vld, d_vld, done;
  logic [DATA_W-1:0] rdata_d;

  // A port's request is invisible in its own ack cycle.
  assign i_vld   = if_req & ~if_ack_q;
  assign d_vld   = d_req & ~d_ack_q;
  assign done    = mem_ready | (cnt_q == TMO_LAST);
  assign rdata_d = mem_ready ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_vld && (!d_vld || last_d_q)) begin
            state_q     <= GNT_I;
            last_d_q    <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
          end else if (d_vld) begin
            state_q     <= GNT_D;
            last_d_q    <= 1'b1;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end
        end
        GNT_I, GNT_D: begin
          // Completion and timeout abort share one path; an abort returns zero data.
          if (done) begin
            if (state_q == GNT_I) begin
              if_rdata_q <= rdata_d;
              if_ack_q   <= 1'b1;
            end else begin
              if (!mem_we_q) d_rdata_q <= rdata_d;
              d_ack_q <= 1'b1;
            end
            if (!mem_ready) err_q <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_ack      = if_ack_q;
  assign d_rdata     = d_rdata_q;
  assign d_ack       = d_ack_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err         = err_q;
  assign stall       = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single transactions plus
// hand-written sequences for contention, alternation and async reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_req, mem_we, stall, err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [64:0] exp_q[$];
  logic [31:0] rd_q[$];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          waits;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .err(err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   cyc, nrdy;
    bit   seen, acked;
    logic ack;
    logic [31:0] rd;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      exp_q.push_back({v.we, v.addr, v.wdata});
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      exp_q.push_back({1'b0, v.addr, 32'h0});
    end
    rd_q.push_back(v.exp_rdata);
    #1 chk({tag, " stall req"}, 65'(stall), 65'd1);
    cyc = 0; nrdy = 0; seen = 1'b0; acked = 1'b0;
    while (!acked && cyc < 40) begin
      step();
      cyc++;
      ack = v.is_d ? d_ack : if_ack;
      rd  = v.is_d ? d_rdata : if_rdata;
      if (ack) begin
        acked = 1'b1;
        chk({tag, " latency"}, 65'(cyc), 65'(v.exp_lat));
        chk({tag, " rdata"}, 65'(rd), 65'(rd_q.pop_front()));
        chk({tag, " err"}, 65'(err), 65'(v.exp_err));
        chk({tag, " stall ack"}, 65'(stall), 65'd0);
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      end else if (mem_req) begin
        if (!seen) begin
          seen = 1'b1;
          chk({tag, " grant cycle"}, 65'(cyc), 65'd1);
          chk({tag, " mem fields"}, {mem_we, mem_addr, mem_wdata}, exp_q.pop_front());
        end else begin
          chk({tag, " addr stable"}, 65'(mem_addr), 65'(v.addr));
        end
        chk({tag, " stall busy"}, 65'(stall), 65'd1);
        mem_ready = (nrdy >= v.waits);
        mem_rdata = v.mrdata;
        nrdy++;
      end
    end
    if (!acked) begin
      chk({tag, " ack within bound"}, 65'd0, 65'd1);
      if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    end
    step();
    ack = v.is_d ? d_ack : if_ack;
    rd  = v.is_d ? d_rdata : if_rdata;
    chk({tag, " ack one cycle"}, 65'(ack), 65'd0);
    chk({tag, " rdata held"}, 65'(rd), 65'(v.exp_rdata));
  endtask

  initial begin
    int g, acks, cyc;

    // fetch, load, store, wait states, timeout, post-error traffic
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h0010_0093, 0, 2, 32'h0010_0093, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h1234_5678, 0, 2, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h7777_7777, 0, 2, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hA5A5_0001, 5, 7, 32'hA5A5_0001, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_0013, 2, 4, 32'h0000_0013, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 1000, 17, 32'h0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_000C, 32'h0, 32'h0000_0011, 0, 2, 32'h0000_0011, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0500, 32'h0BAD_CAFE, 32'h9999_9999, 1, 3, 32'h0, 1'b1};

    // reset state
    step();
    step();
    chk("reset mem_req", 65'(mem_req), 65'd0);
    chk("reset acks", 65'({if_ack, d_ack}), 65'd0);
    chk("reset err", 65'(err), 65'd0);
    chk("reset rdata", 65'({if_rdata, d_rdata}), 65'd0);
    chk("reset mem fields", {mem_we, mem_addr, mem_wdata}, 65'd0);
    chk("reset stall", 65'(stall), 65'd0);
    rst = 1'b1;
    step();

    // simultaneous fetch and store: fetch wins the first tie
    if_req = 1'b1; if_addr = 32'h0000_0010;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hCAFE_F00D;
    exp_q.push_back({1'b0, 32'h0000_0010, 32'h0});
    exp_q.push_back({1'b1, 32'h0000_0100, 32'hCAFE_F00D});
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_0001;
    #1 chk("tie stall", 65'(stall), 65'd1);
    step();
    chk("tie grant I", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, exp_q.pop_front()});
    step();
    chk("tie if_ack", 65'({if_ack, d_ack, mem_req}), 65'b100);
    chk("tie if_rdata", 65'(if_rdata), 65'h0BAD_0001);
    if_req = 1'b0;
    step();
    chk("tie grant D", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, exp_q.pop_front()});
    step();
    chk("tie d_ack", 65'({if_ack, d_ack}), 65'b01);
    chk("store keeps d_rdata", 65'(d_rdata), 65'd0);
    d_req = 1'b0; mem_ready = 1'b0;
    step();

    // both ports held high: grants alternate, one every two cycles
    if_addr = 32'h0000_1000;
    d_we = 1'b0; d_addr = 32'h0000_2000; d_wdata = 32'h0;
    for (int i = 0; i < 6; i++)
      exp_q.push_back((i % 2 == 0) ? {1'b0, 32'h0000_1000, 32'h0} : {1'b0, 32'h0000_2000, 32'h0});
    if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000_5555;
    g = 0; acks = 0; cyc = 0;
    while (acks < 6 && cyc < 30) begin
      step();
      cyc++;
      if (mem_req) begin
        chk($sformatf("alt grant %0d port", g), {mem_we, mem_addr, mem_wdata}, exp_q.pop_front());
        chk($sformatf("alt grant %0d cycle", g), 65'(cyc), 65'(2 * g + 1));
        g++;
      end
      if (if_ack || d_ack) acks++;
      if (acks == 6) begin
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      end
    end
    chk("alt acks within bound", 65'(acks), 65'd6);
    chk("alt scoreboard drained", 65'(exp_q.size()), 65'd0);
    step();
    chk("alt quiet", 65'({mem_req, if_ack, d_ack}), 65'd0);
    step();

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // async reset in the middle of a stalled fetch
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_ready = 1'b0;
    step();
    chk("mid grant", 65'(mem_req), 65'd1);
    step();
    step();
    if_req = 1'b0;
    #2 rst = 1'b0;
    #1 chk("async mem_req drop", 65'(mem_req), 65'd0);
    chk("async err clear", 65'(err), 65'd0);
    chk("async no ack", 65'(if_ack), 65'd0);
    step();
    rst = 1'b1;
    step();
    chk("post reset idle", 65'({mem_req, if_ack, d_ack}), 65'd0);
    run_txn('{1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h0000_0A0A, 0, 2, 32'h0000_0A0A, 1'b0}, "after_rst");

    chk("rd scoreboard drained", 65'(rd_q.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
